envelope_vca: RTL and testbench
===============================

Name: envelope_vca

Overview:
Consumer end of the envelope volume interface. Takes the 8-bit `volume` produced by the ADSR envelope and applies it to a signed voice sample stream with a serial shift-add multiplier. Sits between a voice oscillator and the mixer. Volume changes are deferred to sample zero crossings, with a timeout fallback, to suppress zipper/click noise.

Parameters:
BD, 12, signed sample width in and out
ZC_TIMEOUT, 64, accepted samples without a zero crossing before a forced volume update (1..255)

Ports:
clk  in  1  system clock (8 MHz)
rst  in  1  asynchronous active-high reset
volume  in  8  envelope output, 0 = silent, 255 = unity
sample_in  in  BD  signed two's-complement voice sample
sample_in_valid  in  1  one-cycle strobe, sample_in valid
sample_out  out  BD  signed scaled sample
sample_out_valid  out  1  one-cycle strobe, sample_out valid
busy  out  1  high while a sample is being processed
overrun  out  1  sticky flag, a strobe arrived while busy

Behaviour:
- Reset (async, any time, including mid-multiply):
  - state=IDLE, vol_q=0, sample_out=0, sample_out_valid=0, busy=0, overrun=0.
  - prev_sign=0 (positive), timeout counter=0.
  - Any in-flight sample is discarded; no output strobe is produced for it.
- FSM:
  - IDLE: on sample_in_valid, accept the sample (edge 0) and go to MUL.
  - MUL: 9 iterations, edges 1..9, then go to OUT.
  - OUT: at edge 10, register sample_out, pulse sample_out_valid for one cycle, return to IDLE.
  - busy = (state != IDLE).
  - A new sample may be accepted in the cycle where sample_out_valid is high, so the minimum spacing is 11 cycles.
- Strobe while busy: sample dropped, overrun set to 1 and held until rst. The in-flight computation is unaffected.
- Volume update, decided at accept time (edge 0):
  - vol_q loads `volume` if any of:
    - sample_in == 0
    - sign(sample_in) != prev_sign
    - counter == ZC_TIMEOUT-1
  - Otherwise vol_q holds. The updated vol_q applies to the accepted sample.
  - prev_sign <= sign(sample_in) on every accept.
  - counter resets to 0 on every update; otherwise it increments, saturating at ZC_TIMEOUT-1.
  - `volume` is sampled only at accept; changes at other times are ignored.
- Arithmetic:
  - scale = (vol_q == 255) ? 256 : vol_q, 9 bits.
  - mag = |sample|, BD bits unsigned; -2^(BD-1) gives 2^(BD-1).
  - Shift-add over the 9 scale bits, LSB first, into a BD+9 bit product.
  - res = product >> 8 (truncate), then negated if the input was negative. This rounds toward zero, so the output is sign-symmetric.
  - vol 255 is exact pass-through, including -2048 -> -2048 for BD=12.
  - vol 0 gives 0.
  - |sample_out| <= |sample_in| always, so no overflow is possible.
- sample_out holds its last value between strobes.

Test Plan:
- Reset, then volume=255; feed +1000 (first sample, positive, no crossing; counter=0) -> vol_q stays 0, out 0 at edge 10. Then feed -1000 (crossing) -> vol_q=255, out -1000 exactly 10 cycles after accept, valid high one cycle, busy high 10 cycles.
- vol_q=128 established via a 0 sample; feed +2047 -> +1023; feed -2048 -> -1024; feed -1 -> 0 (toward zero); feed -2048 with vol 255 -> -2048.
- Click suppression: vol_q=200 set via crossing; change volume to 50 and feed +100 x 5 -> outputs 78 each (100*200>>8). Next sample -100 -> -19 (vol 50).
- Timeout: ZC_TIMEOUT=4, vol_q=10; volume=255; feed +500 repeatedly -> samples 1-3 give 19; the 4th (counter=3) forces update and gives 500; counter then restarts.
- Overrun: strobe at edge 0 and again at edge 5 -> second sample ignored, overrun=1 and stays 1; a third strobe at edge 11 is accepted and processed normally.
- Async rst asserted at edge 4 of MUL -> busy=0, no sample_out_valid, outputs and vol_q 0 immediately. After release, a -300 sample with volume=255 gives -300 (sign differs from reset prev_sign).

Source files
------------

// File: rtl/envelope_vca_if.sv
// Bus between a voice source / mixer and the envelope VCA.
interface envelope_vca_if #(
    parameter int unsigned BD = 12
);
    logic [7:0]           volume;
    logic signed [BD-1:0] sample_in;
    logic                 sample_in_valid;
    logic signed [BD-1:0] sample_out;
    logic                 sample_out_valid;
    logic                 busy;
    logic                 overrun;

    // Producer side: supplies volume and samples, observes results.
    modport master (
        output volume,
        output sample_in,
        output sample_in_valid,
        input  sample_out,
        input  sample_out_valid,
        input  busy,
        input  overrun
    );

    // VCA side.
    modport slave (
        input  volume,
        input  sample_in,
        input  sample_in_valid,
        output sample_out,
        output sample_out_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/envelope_vca.sv
// Envelope VCA: scales signed samples by an 8-bit volume using a serial
// shift-add multiplier. Volume changes are deferred to zero crossings of the
// sample stream (or a timeout) to avoid zipper noise.
module envelope_vca #(
    parameter int unsigned BD         = 12,
    parameter int unsigned ZC_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    envelope_vca_if.slave  vca
);

    localparam int unsigned PW = BD + 9;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] TO_LAST = CW'(ZC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           vol_q, vol_d;
    logic                 prev_sign_q, prev_sign_d;
    logic [CW-1:0]        tcnt_q, tcnt_d;
    logic [8:0]           scale_q, scale_d;
    logic [BD-1:0]        mag_q, mag_d;
    logic                 neg_q, neg_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic [3:0]           bit_q, bit_d;
    logic signed [BD-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    // Combinational helpers for the accept decision and the final result.
    logic          sign_in;
    logic          upd;
    logic [7:0]    vol_new;
    logic [BD-1:0] s_u;
    logic [BD-1:0] res_w;

    // State and datapath registers; reset discards any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vol_q       <= '0;
            prev_sign_q <= 1'b0;
            tcnt_q      <= '0;
            scale_q     <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            prod_q      <= '0;
            bit_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vol_q       <= vol_d;
            prev_sign_q <= prev_sign_d;
            tcnt_q      <= tcnt_d;
            scale_q     <= scale_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            prod_q      <= prod_d;
            bit_q       <= bit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state: accept/volume-update logic, shift-add iterations, output.
    always_comb begin
        state_d     = state_q;
        vol_d       = vol_q;
        prev_sign_d = prev_sign_q;
        tcnt_d      = tcnt_q;
        scale_d     = scale_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        prod_d      = prod_q;
        bit_d       = bit_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        s_u     = vca.sample_in;
        sign_in = s_u[BD-1];
        upd     = (s_u == '0) || (sign_in != prev_sign_q) || (tcnt_q == TO_LAST);
        vol_new = upd ? vca.volume : vol_q;
        res_w   = prod_q[BD+7:8];

        unique case (state_q)
            S_IDLE: begin
                if (vca.sample_in_valid) begin
                    vol_d       = vol_new;
                    prev_sign_d = sign_in;
                    tcnt_d      = upd ? '0 : ((tcnt_q == TO_LAST) ? tcnt_q : tcnt_q + CW'(1));
                    scale_d     = (vol_new == 8'hFF) ? 9'd256 : {1'b0, vol_new};
                    // Two's-complement magnitude; the most negative value maps to 2^(BD-1).
                    mag_d       = sign_in ? (~s_u + BD'(1)) : s_u;
                    neg_d       = sign_in;
                    prod_d      = '0;
                    bit_d       = '0;
                    state_d     = S_MUL;
                end
            end
            S_MUL: begin
                if (scale_q[bit_q]) begin
                    prod_d = prod_q + (PW'(mag_q) << bit_q);
                end
                if (bit_q == 4'd8) begin
                    state_d = S_OUT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_OUT: begin
                // Truncate the magnitude before re-applying the sign: rounds toward zero.
                out_d       = neg_q ? (~res_w + BD'(1)) : res_w;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (vca.sample_in_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign vca.sample_out       = out_q;
    assign vca.sample_out_valid = out_valid_q;
    assign vca.busy             = busy_q;
    assign vca.overrun          = overrun_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: one instance with the default zero-cross
// timeout and one with ZC_TIMEOUT=4 for the timeout behaviour.
module tb_envelope_vca;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    envelope_vca_if #(.BD(12)) bus_a ();
    envelope_vca_if #(.BD(12)) bus_t ();

    envelope_vca #(.BD(12), .ZC_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .vca (bus_a)
    );

    envelope_vca #(.BD(12), .ZC_TIMEOUT(4)) dut_t (
        .clk (clk),
        .rst (rst),
        .vca (bus_t)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] vol,
                         input logic signed [11:0] s);
        if (sel) begin
            bus_t.sample_in_valid = v;
            bus_t.volume          = vol;
            bus_t.sample_in       = s;
        end else begin
            bus_a.sample_in_valid = v;
            bus_a.volume          = vol;
            bus_a.sample_in       = s;
        end
    endtask

    function automatic logic get_valid(input bit sel);
        return sel ? bus_t.sample_out_valid : bus_a.sample_out_valid;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus_t.busy : bus_a.busy;
    endfunction

    function automatic logic signed [11:0] get_out(input bit sel);
        return sel ? bus_t.sample_out : bus_a.sample_out;
    endfunction

    // Wait up to max cycles for an output strobe; n = cycles waited or -1.
    task automatic wait_valid(input bit sel, input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk);
            #1;
            if (get_valid(sel)) begin
                n = k;
                break;
            end
        end
    endtask

    // One full transaction: latency, busy duration, result and pulse width.
    task automatic run_sample(input bit sel, input logic [7:0] vol,
                              input logic signed [11:0] s,
                              input logic signed [31:0] exp, input string tag);
        int lat;
        int busy_cnt;
        lat      = -1;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        drive(sel, 1'b1, vol, s);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, vol, s);
        for (int k = 0; k <= 20; k++) begin
            if (get_valid(sel)) begin
                lat = k;
                break;
            end
            if (get_busy(sel)) busy_cnt++;
            @(posedge clk);
            #1;
        end
        check({tag, "_lat"}, lat, 10);
        check({tag, "_busy"}, busy_cnt, 10);
        check({tag, "_out"}, get_out(sel), exp);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, get_valid(sel), 0);
    endtask

    initial begin
        int n;
        int seen;

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 12'sd0);
        drive(1'b1, 1'b0, 8'd0, 12'sd0);
        #1;
        check("rst_out", bus_a.sample_out, 0);
        check("rst_valid", bus_a.sample_out_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_overrun", bus_a.overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // First positive sample: no crossing, volume stays 0.
        run_sample(1'b0, 8'd255, 12'sd1000, 0, "first_pos");
        // Crossing to negative: unity volume.
        run_sample(1'b0, 8'd255, -12'sd1000, -1000, "cross_neg");

        // Volume 128 via a zero sample.
        run_sample(1'b0, 8'd128, 12'sd0, 0, "zero_v128");
        run_sample(1'b0, 8'd128, 12'sd2047, 1023, "p2047_v128");
        run_sample(1'b0, 8'd128, -12'sd2048, -1024, "m2048_v128");
        run_sample(1'b0, 8'd128, -12'sd1, 0, "m1_v128");
        run_sample(1'b0, 8'd255, 12'sd0, 0, "zero_v255");
        run_sample(1'b0, 8'd255, -12'sd2048, -2048, "m2048_v255");

        // Click suppression: 200 latched on crossing, 50 held off until next crossing.
        run_sample(1'b0, 8'd200, 12'sd100, 78, "click_set");
        for (int i = 0; i < 5; i++) begin
            run_sample(1'b0, 8'd50, 12'sd100, 78, "click_hold");
        end
        run_sample(1'b0, 8'd50, -12'sd100, -19, "click_cross");

        // Overrun: second strobe at edge 5 dropped, third at edge 11 accepted.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'd255, 12'sd256);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd255, 12'sd256);
        check("ovr_busy0", bus_a.busy, 1);
        check("ovr_pre", bus_a.overrun, 0);
        repeat (4) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'd255, 12'sd999);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd255, 12'sd999);
        check("ovr_set", bus_a.overrun, 1);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_valid1", bus_a.sample_out_valid, 1);
        check("ovr_out1", bus_a.sample_out, 256);
        drive(1'b0, 1'b1, 8'd255, -12'sd256);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd255, -12'sd256);
        check("ovr_busy3", bus_a.busy, 1);
        wait_valid(1'b0, 15, n);
        check("ovr_lat3", n, 10);
        check("ovr_out3", bus_a.sample_out, -256);
        check("ovr_sticky", bus_a.overrun, 1);

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 8'd255, 12'sd700);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'd255, 12'sd700);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", bus_a.busy, 0);
        check("arst_valid", bus_a.sample_out_valid, 0);
        check("arst_out", bus_a.sample_out, 0);
        check("arst_overrun", bus_a.overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.sample_out_valid) seen++;
        end
        check("arst_no_strobe", seen, 0);
        // vol_q was cleared: a positive sample without crossing stays silent.
        run_sample(1'b0, 8'd255, 12'sd50, 0, "post_rst_vol0");
        run_sample(1'b0, 8'd255, -12'sd300, -300, "post_rst_cross");

        // Timeout on the ZC_TIMEOUT=4 instance.
        run_sample(1'b1, 8'd10, 12'sd0, 0, "to_set10");
        for (int i = 0; i < 3; i++) begin
            run_sample(1'b1, 8'd255, 12'sd500, 19, "to_hold");
        end
        run_sample(1'b1, 8'd255, 12'sd500, 500, "to_force");
        for (int i = 0; i < 3; i++) begin
            run_sample(1'b1, 8'd20, 12'sd500, 500, "to_restart");
        end
        run_sample(1'b1, 8'd20, 12'sd500, 39, "to_force2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
